philo_waiter: RTL
=================

# philo_waiter

Centralized grant controller for an N-seat dining-philosophers ring, acting as the responder for HUNGRY requests. Each seat raises a level request when hungry. The waiter issues at most one new EATING grant per cycle, round-robin from a rotating pointer, and never grants two ring-adjacent seats at once. It holds each grant until the seat signals done, tracks per-seat waiting time, and blocks new grants to the neighbours of any starving seat so that the starving seat is served.

## Interface
- N, 16: number of seats; N ≥ 3; seat N-1 is adjacent to seat 0.
- STARVE_LIMIT, 8: wait cycles before a seat is flagged starving; ≥ 1.
- CW, $clog2(STARVE_LIMIT+1): wait-counter width (derived).
- clock  input  1  sole clock, posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  req[i]=1: seat i is HUNGRY (level).
- done  input  N  done[i]=1: seat i finished eating (one-cycle pulse; ignored unless grant[i]).
- grant  output  N  grant[i]=1: seat i is EATING (registered).
- starve  output  N  starve[i]=1: seat i wait counter is at STARVE_LIMIT (registered).
- eating_cnt  output  $clog2(N+1)  popcount of grant (registered).
- ptr  output  $clog2(N)  current round-robin start index, for observability.

## Operation
- Reset (reset_n low, any time, including mid-grant): grant=0, starve=0, eating_cnt=0, ptr=0, all wait counters 0. Effect is immediate.
- Release: grant[i] & done[i] → grant[i] clears at the next edge.
- Candidate i: req[i] & !grant[i] & !grant[(i-1)%N] & !grant[(i+1)%N], evaluated on the registered grant vector. A neighbour releasing in the same cycle still blocks.
- Starvation block: if starve[j], seats (j-1)%N and (j+1)%N are not candidates. A seat that is itself starving remains eligible.
- Pick: the first candidate scanning ptr, ptr+1, …, ptr+N-1 (mod N). Set grant[pick] at the next edge and set ptr ← (pick+1)%N. With no candidate, ptr holds.
- At most one new grant per cycle. Releases are unlimited per cycle.
- The same seat cannot be released and re-granted in one cycle: a seat with grant[i]&done[i] is not a candidate.
- Grant-to-done is unbounded: the waiter never revokes a grant.
- req[i] dropping while granted has no effect on the grant. Only done releases it.
- Wait counter i:
  - cleared when !req[i], when grant[i] is set, or when seat i is picked;
  - otherwise increments by 1 per cycle, saturating at STARVE_LIMIT.
- starve[i] is registered as (next wait counter == STARVE_LIMIT).
- eating_cnt is registered from the next grant vector.
- Invariant: grant[i]&grant[(i+1)%N] is never 1. eating_cnt ≤ N/2.

## Timing
- req[i] rising before edge k, seat eligible and first in scan → grant[i]=1 after edge k (1-cycle latency).
- done[i] sampled at edge k → grant[i]=0 after edge k.
- A neighbour blocked only by seat i's grant can be granted after edge k+1 at the earliest.
- With req held and seat never picked, starve[i] rises after STARVE_LIMIT edges.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package philo_pkg holds the State enum {THINKING, READING, EATING, HUNGRY} and the helpers for left/right index wrap. The seat-side adapter maps HUNGRY→req and the EATING→THINKING exit→done.
- One sub-module, rr_pick: combinational N-bit first-one-from-pointer finder. Inputs cand[N] and ptr; outputs valid and idx. Implemented as a doubled-vector priority scan.
- The waiter top contains grant, ptr, and wait-counter registers, the candidate mask, and the starvation mask.

## Test plan
- Reset mid-operation: grants 0x0005, assert reset_n=0 → grant=0, ptr=0, starve=0 immediately; deassert, req=0x0001 → grant=0x0001 one edge later.
- All hungry, N=16, req=0xFFFF, no done → one new grant per edge: 0, 2, 4, …, 14. Final grant=0x5555, eating_cnt=8, never adjacent; seat 15 blocked by seats 14 and 0.
- Wrap-around: ptr=15, req=0x8001, grant=0 → seat 15 granted, ptr=0. Seat 0 is never granted while grant[15]=1.
- Simultaneous release and request: grant[3]=1, done[3]=1, req[3]=1, req[4]=1 in one cycle → grant[3]=0, grant[4]=0 after that edge. The next pick follows ptr order; grant[3] and grant[4] are never both 1.
- Starvation, STARVE_LIMIT=4: seats 0 and 2 repeatedly re-granted, seat 1 hungry → starve[1]=1 after 4 edges. Neighbours 0 and 2 are then not re-granted after their done. Seat 1 is granted one edge after both release, and starve[1] then clears.
- done on an ungranted seat, done=0x0010, grant=0 → no state change, ptr unchanged.

Source files
------------

// File: rtl/philo_pkg.sv
// philo_pkg: shared definitions for the dining-philosophers waiter.
//   state_t        : seat state as seen by the seat-side adapter
//   left_of/right_of: ring index wrap helpers (seat n-1 is adjacent to seat 0)
//   seat_req/seat_done: seat-side mapping of state to the waiter's req/done
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  function automatic int unsigned left_of(input int unsigned i, input int unsigned n);
    return (i == 0) ? n - 1 : i - 1;
  endfunction

  function automatic int unsigned right_of(input int unsigned i, input int unsigned n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

  // A hungry seat requests; leaving EATING for THINKING signals done.
  function automatic logic seat_req(input state_t cur);
    return cur == HUNGRY;
  endfunction

  function automatic logic seat_done(input state_t prev, input state_t cur);
    return (prev == EATING) && (cur == THINKING);
  endfunction

endpackage

// File: rtl/philo_waiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
//   cand  : candidate vector
//   ptr   : scan start index
//   valid : at least one candidate is set
//   idx   : first set candidate scanning ptr, ptr+1, ... (mod N)
module rr_pick #(
  parameter int unsigned N  = 16,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW:0]    sum;

  // Shifting the doubled vector rotates the scan origin to bit 0, so the
  // lowest set bit of rot is the offset of the winner from ptr.
  always_comb begin
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[N-1:0];
    valid = |rot;
    sum   = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (rot[k-1]) sum = (PW+1)'(k - 1);
    end
    sum = sum + {1'b0, ptr};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/philo_waiter.sv
// philo_waiter: central grant controller for an N-seat philosophers ring.
//   clock, reset_n : posedge clock, asynchronous active-low reset
//   req[N]         : seat is hungry (level)
//   done[N]        : seat finished eating (pulse, only honoured while granted)
//   grant[N]       : seat is eating (registered)
//   starve[N]      : seat wait counter at STARVE_LIMIT (registered)
//   eating_cnt     : popcount of grant (registered)
//   ptr            : round-robin scan start index
module philo_waiter
  import philo_pkg::*;
#(
  parameter  int unsigned N            = 16,
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CW           = $clog2(STARVE_LIMIT + 1),
  localparam int unsigned PW           = $clog2(N),
  localparam int unsigned EW           = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [N-1:0]  starve,
  output logic [EW-1:0] eating_cnt,
  output logic [PW-1:0] ptr
);

  logic [N-1:0]  cand;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  grant_nxt;
  logic [N-1:0]  starve_nxt;
  logic [EW-1:0] cnt_nxt;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic [CW-1:0] wcnt     [N];
  logic [CW-1:0] wcnt_nxt [N];

  // Candidates use the registered grant, so a neighbour releasing this cycle
  // still blocks, and a seat releasing this cycle cannot be re-granted.
  // Neighbours of a starving seat are held off so it can eventually eat.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand[i] = req[i] & ~grant[i]
              & ~grant[left_of(i, N)]  & ~grant[right_of(i, N)]
              & ~starve[left_of(i, N)] & ~starve[right_of(i, N)];
    end
  end

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_oh = '0;
    if (pick_valid) pick_oh[pick_idx] = 1'b1;

    grant_nxt = (grant & ~done) | pick_oh;

    ptr_nxt = ptr;
    if (pick_valid) ptr_nxt = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;

    cnt_nxt = '0;
    for (int unsigned i = 0; i < N; i++) cnt_nxt = cnt_nxt + EW'(grant_nxt[i]);

    starve_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!req[i] || grant[i] || pick_oh[i])   wcnt_nxt[i] = '0;
      else if (wcnt[i] == CW'(STARVE_LIMIT))   wcnt_nxt[i] = wcnt[i];
      else                                     wcnt_nxt[i] = wcnt[i] + 1'b1;
      starve_nxt[i] = (wcnt_nxt[i] == CW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      starve     <= '0;
      eating_cnt <= '0;
      ptr        <= '0;
      for (int unsigned i = 0; i < N; i++) wcnt[i] <= '0;
    end else begin
      grant      <= grant_nxt;
      starve     <= starve_nxt;
      eating_cnt <= cnt_nxt;
      ptr        <= ptr_nxt;
      for (int unsigned i = 0; i < N; i++) wcnt[i] <= wcnt_nxt[i];
    end
  end

endmodule
